// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game controller and the score display.
//   state_e     : game flow states, exported on game_state
//   WIN_*       : winner codes, exported on winner
//   to_bcd2     : integer 0..99 to two BCD digits (used for the time reload)
//   bcd_dec2    : saturating two-digit BCD decrement (game clock)
//   bcd_inc_sat : saturating one-digit BCD increment (scores)
//   winner_of   : winner code from two final scores
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    function automatic logic [7:0] to_bcd2(input int unsigned value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

    // 00 stays 00; a units digit of 0 wraps to 9 and borrows from the tens.
    function automatic logic [7:0] bcd_dec2(input logic [7:0] bcd);
        logic [7:0] result;
        if (bcd == 8'h00)
            result = 8'h00;
        else if (bcd[3:0] == 4'd0)
            result = {bcd[7:4] - 4'd1, 4'd9};
        else
            result = {bcd[7:4], bcd[3:0] - 4'd1};
        return result;
    endfunction

    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] digit);
        return (digit >= 4'd9) ? 4'd9 : digit + 4'd1;
    endfunction

    function automatic logic [1:0] winner_of(input logic [3:0] p1, input logic [3:0] p2);
        logic [1:0] code;
        if (p1 > p2)
            code = WIN_P1;
        else if (p2 > p1)
            code = WIN_P2;
        else
            code = WIN_TIE;
        return code;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler for the game controller.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear to 0 (asserted on every game state change)
//   en   : count enable (SERVE and PLAY only)
//   tick : one-cycle pulse on the last count of each second
module sec_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = $clog2(CLK_HZ);
    localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= tick ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/pong_game_controller.sv
// Game-flow sequencer for the Pong ball/paddle engine: idle, serve delay,
// rally and game over, plus per-player scores and the countdown game clock.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   start      : start button level; acted on at its rising edge
//   miss1/2    : player 1/2 missed (levels; one event per rising edge)
//   stop       : 1 holds ball and paddles at centre
//   sec1/sec0  : BCD tens/units of remaining game time
//   score1/2   : player scores, BCD 0..9
//   game_state : current state (state_e encoding)
//   winner     : 00 none, 01 P1, 10 P2, 11 tie
module pong_game_controller
    import pong_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_SEC    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miss1,
    input  logic       miss2,
    output logic       stop,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] game_state,
    output logic [1:0] winner
);

    localparam int              SW         = $clog2(SERVE_SEC + 1);
    localparam logic [SW-1:0]   SERVE_LOAD = SW'(SERVE_SEC);
    localparam logic [7:0]      TIME_LOAD  = to_bcd2(GAME_SECONDS);
    localparam logic [3:0]      WIN_BCD    = 4'(WIN_SCORE);

    state_e          state, state_nxt;
    logic [7:0]      time_bcd, time_nxt;
    logic [3:0]      score1_nxt, score2_nxt;
    logic [1:0]      winner_nxt;
    logic [SW-1:0]   serve_cnt, serve_nxt;

    logic            start_prev, miss1_prev, miss2_prev;
    logic            start_ev, miss1_ev, miss2_ev;
    logic            tick, tick_en, tick_clr;
    logic            hit_over, hit_serve;

    assign start_ev = start & ~start_prev;
    assign miss1_ev = miss1 & ~miss1_prev;
    assign miss2_ev = miss2 & ~miss2_prev;

    // The prescaler restarts from 0 in the first cycle of every state.
    assign tick_en  = (state == ST_SERVE) || (state == ST_PLAY);
    assign tick_clr = (state_nxt != state);

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    assign sec1       = time_bcd[7:4];
    assign sec0       = time_bcd[3:0];
    assign game_state = state;

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves any of them unassigned would infer a latch.
        state_nxt  = state;
        time_nxt   = time_bcd;
        score1_nxt = score1;
        score2_nxt = score2;
        winner_nxt = winner;
        serve_nxt  = serve_cnt;
        hit_over   = 1'b0;
        hit_serve  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_ev) begin
                    score1_nxt = 4'd0;
                    score2_nxt = 4'd0;
                    time_nxt   = TIME_LOAD;
                    winner_nxt = WIN_NONE;
                    serve_nxt  = SERVE_LOAD;
                    state_nxt  = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (tick) begin
                    if (serve_cnt <= SW'(1)) begin
                        serve_nxt = '0;
                        state_nxt = ST_PLAY;
                    end else begin
                        serve_nxt = serve_cnt - SW'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    time_nxt = bcd_dec2(time_bcd);
                    hit_over = (time_nxt == 8'h00);
                end
                // A double miss is a dead ball: nobody scores, re-serve.
                if (miss1_ev && miss2_ev) begin
                    hit_serve = 1'b1;
                end else if (miss1_ev) begin
                    score2_nxt = bcd_inc_sat(score2);
                    if (score2_nxt == WIN_BCD) hit_over  = 1'b1;
                    else                       hit_serve = 1'b1;
                end else if (miss2_ev) begin
                    score1_nxt = bcd_inc_sat(score1);
                    if (score1_nxt == WIN_BCD) hit_over  = 1'b1;
                    else                       hit_serve = 1'b1;
                end
                // Time-out wins over a re-serve; the score is already applied.
                if (hit_over) begin
                    winner_nxt = winner_of(score1_nxt, score2_nxt);
                    state_nxt  = ST_OVER;
                end else if (hit_serve) begin
                    serve_nxt  = SERVE_LOAD;
                    state_nxt  = ST_SERVE;
                end
            end

            ST_OVER: begin
                if (start_ev) state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            stop       <= 1'b1;
            time_bcd   <= TIME_LOAD;
            score1     <= 4'd0;
            score2     <= 4'd0;
            winner     <= WIN_NONE;
            serve_cnt  <= '0;
            start_prev <= 1'b0;
            miss1_prev <= 1'b0;
            miss2_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values;
            // blocking here would let later lines see this cycle's updates.
            state      <= state_nxt;
            stop       <= (state_nxt != ST_PLAY);
            time_bcd   <= time_nxt;
            score1     <= score1_nxt;
            score2     <= score2_nxt;
            winner     <= winner_nxt;
            serve_cnt  <= serve_nxt;
            start_prev <= start;
            miss1_prev <= miss1;
            miss2_prev <= miss2;
        end
    end

endmodule

// File: tb/tb_pong_game_controller.sv
// Self-checking bench for pong_game_controller with a small game configuration.
// Directed scenarios plus a randomized run, all compared against an
// integer-level model of the game rules kept in this file.
module tb_pong_game_controller;

    localparam int CLK_HZ       = 4;
    localparam int GAME_SECONDS = 12;
    localparam int WIN_SCORE    = 3;
    localparam int SERVE_SEC    = 1;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_OVER  = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       miss1 = 1'b0;
    logic       miss2 = 1'b0;
    logic       stop;
    logic [3:0] sec1, sec0, score1, score2;
    logic [1:0] game_state, winner;

    int errors = 0;
    int checks = 0;

    pong_game_controller #(
        .CLK_HZ       (CLK_HZ),
        .GAME_SECONDS (GAME_SECONDS),
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_SEC    (SERVE_SEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .miss1      (miss1),
        .miss2      (miss2),
        .stop       (stop),
        .sec1       (sec1),
        .sec0       (sec0),
        .score1     (score1),
        .score2     (score2),
        .game_state (game_state),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (game rules, integer seconds) -------
    int m_st, m_time, m_s1, m_s2, m_win, m_serve_left, m_sub;
    bit m_stop, p_start, p_m1, p_m2;

    function automatic void model_reset();
        m_st = S_IDLE; m_time = GAME_SECONDS; m_s1 = 0; m_s2 = 0; m_win = 0;
        m_serve_left = 0; m_sub = 0; m_stop = 1'b1;
        p_start = 1'b0; p_m1 = 1'b0; p_m2 = 1'b0;
    endfunction

    function automatic void model_step();
        bit se, e1, e2, sec_done, over, reserve, running;
        int nst;
        if (rst === 1'b0) begin
            model_reset();
            return;
        end
        se = start && !p_start;
        e1 = miss1 && !p_m1;
        e2 = miss2 && !p_m2;
        p_start = start; p_m1 = miss1; p_m2 = miss2;
        running  = (m_st == S_SERVE) || (m_st == S_PLAY);
        sec_done = running && (m_sub == CLK_HZ - 1);
        nst = m_st;
        over = 0; reserve = 0;
        case (m_st)
            S_IDLE: if (se) begin
                m_s1 = 0; m_s2 = 0; m_time = GAME_SECONDS; m_win = 0;
                m_serve_left = SERVE_SEC; nst = S_SERVE;
            end
            S_SERVE: if (sec_done) begin
                m_serve_left--;
                if (m_serve_left <= 0) nst = S_PLAY;
            end
            S_PLAY: begin
                if (sec_done && m_time > 0) begin
                    m_time--;
                    if (m_time == 0) over = 1;
                end
                if (e1 && e2) reserve = 1;
                else if (e1) begin
                    if (m_s2 < 9) m_s2++;
                    if (m_s2 == WIN_SCORE) over = 1; else reserve = 1;
                end else if (e2) begin
                    if (m_s1 < 9) m_s1++;
                    if (m_s1 == WIN_SCORE) over = 1; else reserve = 1;
                end
                if (over) begin
                    m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
                    nst = S_OVER;
                end else if (reserve) begin
                    m_serve_left = SERVE_SEC; nst = S_SERVE;
                end
            end
            default: if (se) nst = S_IDLE;
        endcase
        if (nst != m_st)    m_sub = 0;
        else if (sec_done)  m_sub = 0;
        else if (running)   m_sub = m_sub + 1;
        else                m_sub = 0;
        m_st = nst;
        m_stop = (nst != S_PLAY);
    endfunction

    function automatic logic [20:0] model_vec();
        return {2'(m_st), m_stop, 4'(m_time / 10), 4'(m_time % 10),
                4'(m_s1), 4'(m_s2), 2'(m_win)};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {game_state, stop, sec1, sec0, score1, score2, winner};
    endfunction

    // ---------------- stimulus helpers ----------------------------------
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_cycle();
        start = 1'b0;
        tick_cycle();
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        while (game_state !== 2'd2 && n < 40) begin
            tick_cycle();
            n++;
        end
        checks++;
        if (game_state !== 2'd2) begin
            errors++;
            $display("FAIL %s: no PLAY within 40 cycles, state=%0d", tag, game_state);
        end
    endtask

    // ---------------- scenarios -----------------------------------------
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({game_state, stop} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: state=%0d stop=%0b, need 0/1", game_state, stop);
        end
        checks++;
        if ({sec1, sec0} !== 8'h12) begin
            errors++;
            $display("FAIL reset_time: got %h need 12", {sec1, sec0});
        end
        checks++;
        if ({score1, score2, winner} !== 10'd0) begin
            errors++;
            $display("FAIL reset_scores: s1=%0d s2=%0d win=%0d, need 0", score1, score2, winner);
        end
        rst = 1'b1;
        repeat (3) tick_cycle();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL idle_hold: got %h need %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_start_serve();
        int n = 0;
        int bad_stop = 0;
        start = 1'b1;
        tick_cycle();
        start = 1'b0;
        while (game_state === 2'd1 && n < 20) begin
            if (stop !== 1'b1) bad_stop++;
            tick_cycle();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL serve_len: SERVE lasted %0d cycles, need 4", n);
        end
        checks++;
        if (bad_stop != 0) begin
            errors++;
            $display("FAIL serve_stop: stop low in %0d SERVE cycles, need 0", bad_stop);
        end
        checks++;
        if ({game_state, stop, sec1, sec0} !== {2'd2, 1'b0, 4'd1, 4'd2}) begin
            errors++;
            $display("FAIL play_entry: state=%0d stop=%0b time=%h, need 2/0/12",
                     game_state, stop, {sec1, sec0});
        end
    endtask

    task automatic test_miss_hold();
        miss1 = 1'b1;
        tick_cycle();
        checks++;
        if ({score2, game_state, stop} !== {4'd1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL miss_score: s2=%0d state=%0d stop=%0b, need 1/1/1",
                     score2, game_state, stop);
        end
        repeat (4) tick_cycle();
        checks++;
        if ({game_state, stop} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL reserve_len: state=%0d stop=%0b, need 2/0", game_state, stop);
        end
        repeat (5) tick_cycle();
        checks++;
        if ({score1, score2, game_state} !== {4'd0, 4'd1, 2'd2}) begin
            errors++;
            $display("FAIL miss_once: s1=%0d s2=%0d state=%0d, need 0/1/2",
                     score1, score2, game_state);
        end
        miss1 = 1'b0;
        tick_cycle();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL miss_model: got %h need %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_win_p1();
        logic [7:0] t_over;
        for (int k = 0; k < 3; k++) begin
            wait_play("win_p1");
            miss2 = 1'b1;
            tick_cycle();
            miss2 = 1'b0;
            checks++;
            if (score1 !== 4'(k + 1)) begin
                errors++;
                $display("FAIL p1_score%0d: got %0d need %0d", k, score1, k + 1);
            end
        end
        checks++;
        if ({game_state, stop, winner, score2} !== {2'd3, 1'b1, 2'b01, 4'd1}) begin
            errors++;
            $display("FAIL p1_over: state=%0d stop=%0b win=%0d s2=%0d, need 3/1/1/1",
                     game_state, stop, winner, score2);
        end
        t_over = {sec1, sec0};
        repeat (12) tick_cycle();
        checks++;
        if ({sec1, sec0} !== t_over || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL over_frozen: got %h need %h (time at over %h)",
                     dut_vec(), model_vec(), t_over);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit saw_borrow = 0;
        logic [7:0] prev_t = 8'h12;
        pulse_start();
        checks++;
        if (game_state !== 2'd0) begin
            errors++;
            $display("FAIL over_to_idle: state=%0d need 0", game_state);
        end
        pulse_start();
        wait_play("timeout");
        while (game_state === 2'd2 && n < 100) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL countdown c%0d: got %h need %h", n, dut_vec(), model_vec());
            end
            if ({sec1, sec0} === 8'h09 && prev_t === 8'h10) saw_borrow = 1;
            prev_t = {sec1, sec0};
            tick_cycle();
            n++;
        end
        checks++;
        if (n != 48) begin
            errors++;
            $display("FAIL play_len: PLAY lasted %0d cycles, need 48", n);
        end
        checks++;
        if (!saw_borrow) begin
            errors++;
            $display("FAIL bcd_borrow: 10 -> 09 step got 0 need 1");
        end
        checks++;
        if ({game_state, winner, sec1, sec0, stop} !== {2'd3, 2'b11, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL timeout_over: state=%0d win=%0d time=%h stop=%0b, need 3/3/00/1",
                     game_state, winner, {sec1, sec0}, stop);
        end
    endtask

    task automatic test_both_miss();
        pulse_start();
        pulse_start();
        wait_play("both_miss");
        miss1 = 1'b1;
        miss2 = 1'b1;
        tick_cycle();
        checks++;
        if ({score1, score2, game_state, stop} !== {4'd0, 4'd0, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL both_miss: s1=%0d s2=%0d state=%0d stop=%0b, need 0/0/1/1",
                     score1, score2, game_state, stop);
        end
        miss1 = 1'b0;
        miss2 = 1'b0;
        tick_cycle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            wait_play("rst_setup");
            miss2 = 1'b1;
            tick_cycle();
            miss2 = 1'b0;
        end
        wait_play("rst_setup");
        checks++;
        if ({score1, game_state} !== {4'd2, 2'd2}) begin
            errors++;
            $display("FAIL rst_setup: s1=%0d state=%0d, need 2/2", score1, game_state);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== {2'd0, 1'b1, 8'h12, 4'd0, 4'd0, 2'd0}) begin
            errors++;
            $display("FAIL async_rst: got %h need %h", dut_vec(),
                     {2'd0, 1'b1, 8'h12, 4'd0, 4'd0, 2'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_play("p2_win");
            miss1 = 1'b1;
            tick_cycle();
            miss1 = 1'b0;
        end
        checks++;
        if ({game_state, winner, score2} !== {2'd3, 2'b10, 4'd3}) begin
            errors++;
            $display("FAIL p2_over: state=%0d win=%0d s2=%0d, need 3/2/3",
                     game_state, winner, score2);
        end
        pulse_start();
        checks++;
        if (game_state !== 2'd0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL restart_idle: got %h need %h", dut_vec(), model_vec());
        end
        start = 1'b1;
        tick_cycle();
        start = 1'b0;
        checks++;
        if (dut_vec() !== {2'd1, 1'b1, 8'h12, 4'd0, 4'd0, 2'd0}) begin
            errors++;
            $display("FAIL new_game: got %h need %h", dut_vec(),
                     {2'd1, 1'b1, 8'h12, 4'd0, 4'd0, 2'd0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 399) != 0);
            start = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 5) == 0) miss1 = ~miss1;
            if ($urandom_range(0, 5) == 0) miss2 = ~miss2;
            tick_cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random c%0d: got %h need %h", i, dut_vec(), model_vec());
            end
        end
        rst = 1'b1; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
        tick_cycle();
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_miss_hold();
        test_win_p1();
        test_timeout();
        test_both_miss();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
